latch_bank_feeder: RTL and testbench

// - Upstream feeder for the 4-bit NAND latch bank: drives its 4 data lines and its active-high

---
 rtl/kmstln_pkg.sv | 17 +
 rtl/key_shift_cmp.sv | 43 ++++
 rtl/latch_bank_feeder.sv | 120 ++++++++++++
 tb/tb_latch_bank_feeder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/kmstln_pkg.sv
// Shared types and constants for the latch bank feeder: FSM states, latch width and default unlock key.
package kmstln_pkg;

  typedef enum logic [2:0] {
    LOCKED,
    IDLE,
    SETUP,
    ENABLE,
    HOLD
  } state_t;

  localparam int unsigned LATCH_WIDTH     = 4;
  localparam int unsigned DEFAULT_KEY_LEN = 8;
  localparam logic [DEFAULT_KEY_LEN-1:0] DEFAULT_KEY = 8'hA5;
  localparam int unsigned EN_CNT_W        = 4;

endpackage

// File: rtl/key_shift_cmp.sv
// Serial key capture: MSB-first shift register plus bit counter, compared against KEY on the last bit.
module key_shift_cmp
  import kmstln_pkg::*;
#(
  parameter int unsigned        KEY_LEN = DEFAULT_KEY_LEN,
  parameter logic [KEY_LEN-1:0] KEY     = KEY_LEN'(DEFAULT_KEY)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_i,
  input  logic vld_i,
  input  logic clr_i,
  output logic match_p,
  output logic mismatch_p
);

  localparam int unsigned CNT_W = $clog2(KEY_LEN + 1);

  logic [KEY_LEN-1:0] sr_q;
  logic [KEY_LEN-1:0] sr_next;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_bit;

  // Compare includes the bit arriving this cycle, so the verdict is available at the KEY_LEN-th edge.
  assign sr_next    = {sr_q[KEY_LEN-2:0], bit_i};
  assign last_bit   = vld_i && (cnt_q == CNT_W'(KEY_LEN - 1));
  assign match_p    = last_bit && (sr_next == KEY);
  assign mismatch_p = last_bit && (sr_next != KEY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i || last_bit) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (vld_i) begin
      sr_q  <= sr_next;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/latch_bank_feeder.sv
// Key-locked feeder for the 4-bit NAND latch bank: sequences setup / enable / hold around each accepted word.
module latch_bank_feeder
  import kmstln_pkg::*;
#(
  parameter int unsigned        WIDTH     = LATCH_WIDTH,
  parameter int unsigned        KEY_LEN   = DEFAULT_KEY_LEN,
  parameter logic [KEY_LEN-1:0] KEY       = KEY_LEN'(DEFAULT_KEY),
  parameter int unsigned        EN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_bit_i,
  input  logic             key_vld_i,
  input  logic             relock_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] lat_d_o,
  output logic             lat_en_o,
  output logic             unlocked_o,
  output logic             key_err_o
);

  state_t              state_q, state_d;
  logic [EN_CNT_W-1:0] en_cnt_q, en_cnt_d;
  logic [WIDTH-1:0]    lat_d_d;
  logic                lat_en_d, s_ready_d, unlocked_d, key_err_d;
  logic                key_vld_gated, match_p, mismatch_p;

  // Key bits only count while locked, and a concurrent relock discards them.
  assign key_vld_gated = key_vld_i && (state_q == LOCKED) && !relock_i;

  key_shift_cmp #(
    .KEY_LEN (KEY_LEN),
    .KEY     (KEY)
  ) u_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_i      (key_bit_i),
    .vld_i      (key_vld_gated),
    .clr_i      (relock_i),
    .match_p    (match_p),
    .mismatch_p (mismatch_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOCKED;
      en_cnt_q   <= '0;
      lat_d_o    <= '0;
      lat_en_o   <= 1'b0;
      s_ready_o  <= 1'b0;
      unlocked_o <= 1'b0;
      key_err_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_cnt_q   <= en_cnt_d;
      lat_d_o    <= lat_d_d;
      lat_en_o   <= lat_en_d;
      s_ready_o  <= s_ready_d;
      unlocked_o <= unlocked_d;
      key_err_o  <= key_err_d;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d    = state_q;
    en_cnt_d   = en_cnt_q;
    lat_d_d    = lat_d_o;
    lat_en_d   = 1'b0;
    s_ready_d  = 1'b0;
    unlocked_d = unlocked_o;
    key_err_d  = 1'b0;
    if (relock_i) begin
      state_d    = LOCKED;
      en_cnt_d   = '0;
      lat_d_d    = '0;
      unlocked_d = 1'b0;
    end else begin
      case (state_q)
        LOCKED: begin
          key_err_d = mismatch_p;
          if (match_p) begin
            state_d    = IDLE;
            unlocked_d = 1'b1;
            s_ready_d  = 1'b1;
          end
        end
        IDLE: begin
          s_ready_d = 1'b1;
          if (s_valid_i && s_ready_o) begin
            lat_d_d   = s_data_i;
            state_d   = SETUP;
            s_ready_d = 1'b0;
          end
        end
        SETUP: begin
          state_d  = ENABLE;
          lat_en_d = 1'b1;
          en_cnt_d = EN_CNT_W'(EN_CYCLES - 1);
        end
        ENABLE: begin
          if (en_cnt_q == '0) begin
            state_d = HOLD;
          end else begin
            lat_en_d = 1'b1;
            en_cnt_d = en_cnt_q - EN_CNT_W'(1);
          end
        end
        HOLD: begin
          state_d   = IDLE;
          s_ready_d = 1'b1;
        end
        default: state_d = LOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_feeder.sv
// Bench for latch_bank_feeder: two instances (EN_CYCLES 1 and 4) checked every cycle against a timeline model.
module tb_latch_bank_feeder;

  localparam int BIG = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kb[2], kv[2], rl[2], sv[2];
  logic [3:0] sd[2];
  logic       srdy[2], len[2], unl[2], kerr[2];
  logic [3:0] ld[2];

  int         checks = 0;
  int         errors = 0;
  int         enc[2] = '{1, 4};
  logic [7:0] keyv = 8'hA5;

  // Model: lock status, key progress, cycles since last accept, latched word.
  int         m_unl[2], m_sr[2], m_cnt[2], m_since[2], m_err[2], m_acc[2];
  logic [3:0] m_ld[2];
  logic [3:0] bank[2];
  int         cyc = 0;
  logic       prev_en0 = 1'b0;
  int         rise_t[$];

  always #5 clk = ~clk;

  latch_bank_feeder #(.EN_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .key_bit_i(kb[0]), .key_vld_i(kv[0]), .relock_i(rl[0]),
    .s_data_i(sd[0]), .s_valid_i(sv[0]), .s_ready_o(srdy[0]), .lat_d_o(ld[0]),
    .lat_en_o(len[0]), .unlocked_o(unl[0]), .key_err_o(kerr[0])
  );

  latch_bank_feeder #(.EN_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .key_bit_i(kb[1]), .key_vld_i(kv[1]), .relock_i(rl[1]),
    .s_data_i(sd[1]), .s_valid_i(sv[1]), .s_ready_o(srdy[1]), .lat_d_o(ld[1]),
    .lat_en_o(len[1]), .unlocked_o(unl[1]), .key_err_o(kerr[1])
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_unl[i] = 0; m_sr[i] = 0; m_cnt[i] = 0; m_since[i] = BIG;
      m_err[i] = 0; m_acc[i] = 0; m_ld[i] = 4'h0;
    end
  endtask

  task automatic model_edge(input int i);
    m_acc[i] = 0;
    if (rl[i]) begin
      m_unl[i] = 0; m_sr[i] = 0; m_cnt[i] = 0; m_ld[i] = 4'h0; m_err[i] = 0; m_since[i] = BIG;
    end else if (m_unl[i] == 0) begin
      m_err[i] = 0;
      if (kv[i]) begin
        m_sr[i]  = ((m_sr[i] << 1) | int'(kb[i])) & 255;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == 8) begin
          if (m_sr[i] == int'(keyv)) begin
            m_unl[i] = 1; m_since[i] = BIG;
          end else begin
            m_err[i] = 1;
          end
          m_sr[i] = 0; m_cnt[i] = 0;
        end
      end
    end else begin
      m_err[i] = 0;
      if (m_since[i] >= enc[i] + 2 && sv[i]) begin
        m_ld[i] = sd[i]; m_since[i] = 0; m_acc[i] = 1;
      end else if (m_since[i] < BIG) begin
        m_since[i] = m_since[i] + 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic e_rdy, e_en;
      e_rdy = (m_unl[i] != 0) && (m_since[i] >= enc[i] + 2);
      e_en  = (m_unl[i] != 0) && (m_since[i] >= 1) && (m_since[i] <= enc[i]);
      check($sformatf("u%0d.s_ready c%0d", enc[i], cyc), 4'(srdy[i]), 4'(e_rdy));
      check($sformatf("u%0d.lat_en c%0d", enc[i], cyc), 4'(len[i]), 4'(e_en));
      check($sformatf("u%0d.unlocked c%0d", enc[i], cyc), 4'(unl[i]), 4'(m_unl[i] != 0));
      check($sformatf("u%0d.key_err c%0d", enc[i], cyc), 4'(kerr[i]), 4'(m_err[i] != 0));
      check($sformatf("u%0d.lat_d c%0d", enc[i], cyc), ld[i], m_ld[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cyc++;
    compare_all();
    for (int i = 0; i < 2; i++) if (len[i]) bank[i] = ld[i];
    if (len[0] && !prev_en0) rise_t.push_back(cyc);
    prev_en0 = len[0];
  endtask

  task automatic set_all(input logic k_b, input logic k_v, input logic r, input logic v, input logic [3:0] d);
    for (int i = 0; i < 2; i++) begin
      kb[i] = k_b; kv[i] = k_v; rl[i] = r; sv[i] = v; sd[i] = d;
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    for (int b = 7; b >= 0; b--) begin
      set_all(k[b], 1'b1, 1'b0, 1'b0, 4'h0);
      step();
    end
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
  endtask

  task automatic feed_two(input logic [3:0] a, input logic [3:0] b, input int ncyc);
    int pos[2];
    pos = '{0, 0};
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 2; i++) begin
        sv[i] = (pos[i] < 2);
        sd[i] = (pos[i] == 0) ? a : b;
      end
      step();
      for (int i = 0; i < 2; i++) if (m_acc[i] != 0) pos[i]++;
    end
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    bank = '{4'h0, 4'h0};
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    step();

    // Wrong key: one error pulse, stays locked; then the right key unlocks.
    send_key(8'hA4);
    send_key(8'hA5);

    // Single word 4'hB through the full setup / enable / hold sequence.
    set_all(1'b0, 1'b0, 1'b0, 1'b1, 4'hB);
    step();
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (7) step();
    check("bank1 holds B", bank[0], 4'hB);
    check("bank4 holds B", bank[1], 4'hB);

    // Back-to-back words with valid held high.
    rise_t.delete();
    feed_two(4'h3, 4'hC, 14);
    check("pulse count u1", 4'(rise_t.size()), 4'd2);
    if (rise_t.size() >= 2) check("pulse spacing u1", 4'(rise_t[1] - rise_t[0]), 4'd4);
    repeat (4) step();

    // Relock in the middle of the EN_CYCLES=4 pulse.
    set_all(1'b0, 1'b0, 1'b0, 1'b1, 4'h6);
    step();
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (2) step();
    set_all(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step();
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Partial key, relock with a simultaneous key bit, then a fresh full key.
    for (int b = 0; b < 3; b++) begin
      set_all(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
    end
    set_all(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    send_key(8'hA5);

    // Locked with valid words offered: nothing moves.
    set_all(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step();
    set_all(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    repeat (20) step();
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Asynchronous reset while the EN_CYCLES=4 instance is mid-pulse.
    send_key(8'hA5);
    set_all(1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
    step();
    set_all(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (2) step();
    check("u4 in pulse before reset", 4'(len[1]), 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
    step();

    // Randomized traffic: mostly-correct key bits, random words, rare relocks.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        kv[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8 && m_unl[i] == 0) kb[i] = keyv[7 - m_cnt[i]];
        else kb[i] = 1'($urandom_range(0, 1));
        rl[i] = ($urandom_range(0, 79) == 0);
        sv[i] = 1'($urandom_range(0, 1));
        sd[i] = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
